// File: rtl/jalr_hazard_ctrl_pkg.sv
// Shared definitions for the JALR target-resolution scheduler and its hazard helpers.
// FSM encoding, forwarding-select codes and the register-match helper.
package jalr_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STALL = 2'd1,
      ST_GO    = 2'd2
   } jalr_state_e;

   localparam logic [1:0] FRW_RF    = 2'b00;
   localparam logic [1:0] FRW_EXMEM = 2'b01;
   localparam logic [1:0] FRW_MEMWB = 2'b10;

   localparam logic [4:0] REG_ZERO  = 5'd0;

   // x0 is never a real producer, so a write to it can never create a dependency.
   function automatic logic rd_match(input logic       wr_en,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
      return wr_en && (rd != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/jalr_need_calc.sv
// Combinational rs1 dependency check: stall cycles still needed and the forwarding source.
// Pure logic, zero latency; no flow control.
module jalr_need_calc
   import jalr_hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs1_i,
   input  logic [4:0] idex_rd_i,
   input  logic       idex_wr_en_i,
   input  logic       idex_mem_rd_i,
   input  logic [4:0] exmem_rd_i,
   input  logic       exmem_wr_en_i,
   input  logic       exmem_mem_rd_i,
   input  logic [4:0] memwb_rd_i,
   input  logic       memwb_wr_en_i,
   output logic [1:0] need_o,
   output logic [1:0] frw_o
);

   logic m_idex;
   logic m_exmem;
   logic m_memwb;

   assign m_idex  = rd_match(idex_wr_en_i,  idex_rd_i,  rs1_i);
   assign m_exmem = rd_match(exmem_wr_en_i, exmem_rd_i, rs1_i);
   assign m_memwb = rd_match(memwb_wr_en_i, memwb_rd_i, rs1_i);

   always_comb begin
      need_o = 2'd0;
      if (m_idex && idex_mem_rd_i) begin
         need_o = 2'd2;
      end else if (m_idex) begin
         need_o = 2'd1;
      end else if (m_exmem && exmem_mem_rd_i) begin
         need_o = 2'd1;
      end
   end

   // The younger producer in EX/MEM holds the newer value, so it wins over MEM/WB.
   always_comb begin
      frw_o = FRW_RF;
      if (m_exmem) begin
         frw_o = FRW_EXMEM;
      end else if (m_memwb) begin
         frw_o = FRW_MEMWB;
      end
   end

endmodule

// File: rtl/jalr_hazard_ctrl.sv
// ID-stage JALR scheduler: holds PC/IF-ID and bubbles ID/EX until rs1 is forwardable, then strobes JalrGo.
// Zero latency when no hazard; otherwise JalrGo on the cycle after the last of Need stall cycles.
module jalr_hazard_ctrl
   import jalr_hazard_ctrl_pkg::*;
#(
   parameter int PERF_W = 16,
   parameter int CNT_W  = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IFID_IsJALR,
   input  logic [4:0]        IFID_Rs1,
   input  logic [4:0]        IDEX_Rd,
   input  logic              IDEX_RegWrEn,
   input  logic              IDEX_MemRd,
   input  logic [4:0]        EXMEM_Rd,
   input  logic              EXMEM_RegWrEn,
   input  logic              EXMEM_MemRd,
   input  logic [4:0]        MEMWB_Rd,
   input  logic              MEMWB_RegWrEn,
   input  logic              Flush,
   input  logic              PerfClr,
   output logic              Stall,
   output logic              IDEX_Bubble,
   output logic              JalrGo,
   output logic [1:0]        FrwF,
   output logic [PERF_W-1:0] PerfStallCnt
);

   jalr_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PERF_W-1:0] perf_q, perf_d;
   logic [1:0]        need;
   logic [1:0]        frw_calc;

   jalr_need_calc u_need (
      .rs1_i          (IFID_Rs1),
      .idex_rd_i      (IDEX_Rd),
      .idex_wr_en_i   (IDEX_RegWrEn),
      .idex_mem_rd_i  (IDEX_MemRd),
      .exmem_rd_i     (EXMEM_Rd),
      .exmem_wr_en_i  (EXMEM_RegWrEn),
      .exmem_mem_rd_i (EXMEM_MemRd),
      .memwb_rd_i     (MEMWB_Rd),
      .memwb_wr_en_i  (MEMWB_RegWrEn),
      .need_o         (need),
      .frw_o          (frw_calc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perf_q  <= perf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (Flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (IFID_IsJALR && need == 2'd2) begin
                  state_d = ST_STALL;
                  cnt_d   = '0;
               end else if (IFID_IsJALR && need == 2'd1) begin
                  state_d = ST_GO;
               end
            end
            ST_STALL: begin
               if (cnt_q == '0) begin
                  state_d = ST_GO;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_GO:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // While reset is asserted the outputs are forced low even though IF/ID may still hold a JALR.
   always_comb begin
      Stall       = 1'b0;
      IDEX_Bubble = 1'b0;
      JalrGo      = 1'b0;
      FrwF        = FRW_RF;
      if (rst_n && !Flush) begin
         unique case (state_q)
            ST_IDLE: begin
               if (IFID_IsJALR && need == 2'd0) begin
                  JalrGo = 1'b1;
                  FrwF   = frw_calc;
               end else if (IFID_IsJALR) begin
                  Stall       = 1'b1;
                  IDEX_Bubble = 1'b1;
               end
            end
            ST_STALL: begin
               Stall       = 1'b1;
               IDEX_Bubble = 1'b1;
            end
            ST_GO: begin
               JalrGo = 1'b1;
               FrwF   = frw_calc;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      perf_d = perf_q;
      if (PerfClr) begin
         perf_d = '0;
      end else if (Stall && perf_q != '1) begin
         perf_d = perf_q + PERF_W'(1);
      end
   end

   assign PerfStallCnt = perf_q;

endmodule
